// File: rtl/load_control_pkg.sv
// Shared constants and types for the load path: opcode/funct3 encodings,
// address-region nibbles, region and FSM enums, and small decode helpers.
// Optional feature macro used by the load path: LOAD_CONTROL_MISALIGN_EN.
package load_control_pkg;

   // Major opcode for loads (RV32I).
   localparam logic [6:0] OPC_LOAD = 7'b0000011;

   // Load funct3 encodings; 3'b011, 3'b110, 3'b111 are reserved.
   localparam logic [2:0] FNC_LB  = 3'b000;
   localparam logic [2:0] FNC_LH  = 3'b001;
   localparam logic [2:0] FNC_LW  = 3'b010;
   localparam logic [2:0] FNC_LBU = 3'b100;
   localparam logic [2:0] FNC_LHU = 3'b101;

   // Address nibble addr[31:28] for the single-code regions.
   // DMEM is the 4'b00x1 pair and is matched by the decode function.
   localparam logic [3:0] NIB_BIOS = 4'b0100;
   localparam logic [3:0] NIB_MMIO = 4'b1000;

   typedef enum logic [1:0] {
      REGION_NONE = 2'd0,
      REGION_DMEM = 2'd1,
      REGION_BIOS = 2'd2,
      REGION_MMIO = 2'd3
   } region_t;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_WAIT_MMIO = 1'b1
   } state_t;

   // Map the top address nibble onto a memory region.
   function automatic region_t decode_region(input logic [3:0] nib);
      region_t r;
      r = REGION_NONE;
      if ((nib[3:2] == 2'b00) && nib[0]) begin
         r = REGION_DMEM;
      end else if (nib == NIB_BIOS) begin
         r = REGION_BIOS;
      end else if (nib == NIB_MMIO) begin
         r = REGION_MMIO;
      end
      return r;
   endfunction

   // Halfwords need an even offset, words a zero offset; bytes never misalign.
   function automatic logic is_misaligned(input logic [2:0] fnc, input logic [1:0] off);
      logic m;
      m = 1'b0;
      if ((fnc == FNC_LH) || (fnc == FNC_LHU)) begin
         m = off[0];
      end else if (fnc == FNC_LW) begin
         m = (off != 2'b00);
      end
      return m;
   endfunction

endpackage

// File: rtl/load_control_align.sv
// load_align: extracts the addressed byte/halfword from a returned word and
// sign- or zero-extends it. Purely combinational. Words pass through
// unshifted; bytes shifted in from above bit 31 are zero; reserved funct3
// codes produce zero.
module load_align
   import load_control_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  fnc,
   input  logic [1:0]  offset,
   output logic [31:0] wb_data
);

   logic [31:0] raw;

   // Shift the addressed lane down to bit 0, then extend by access type.
   always_comb begin
      raw     = rdata >> {offset, 3'b000};
      wb_data = '0;
      case (fnc)
         FNC_LB:  wb_data = {{24{raw[7]}}, raw[7:0]};
         FNC_LBU: wb_data = {24'h000000, raw[7:0]};
         FNC_LH:  wb_data = {{16{raw[15]}}, raw[15:0]};
         FNC_LHU: wb_data = {16'h0000, raw[15:0]};
         FNC_LW:  wb_data = rdata;
         default: wb_data = '0;
      endcase
   end

endmodule

// File: rtl/load_control.sv
// load_control: decodes loads in EX, raises the DMEM/BIOS read enable or an
// MMIO request, remembers the access shape for one cycle (or until the MMIO
// read returns / times out) and produces the aligned writeback value.
// Stalls IF/ID/EX while an MMIO read is outstanding.
// Optional feature macro: LOAD_CONTROL_MISALIGN_EN adds the misalign port and
// turns misaligned loads into zero-data completions without MMIO traffic.
module load_control
   import load_control_pkg::*;
#(
   parameter int MMIO_TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [6:0]  ex_opcode,
   input  logic [2:0]  ex_fnc,
   input  logic [31:0] ex_addr,
   output logic        dmem_en,
   output logic        bios_en,
   output logic        mmio_req,
   input  logic [31:0] dmem_rdata,
   input  logic [31:0] bios_rdata,
   input  logic [31:0] mmio_rdata,
   input  logic        mmio_rvalid,
   output logic        stall,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic        mmio_timeout
`ifdef LOAD_CONTROL_MISALIGN_EN
   ,
   output logic        misalign
`endif
);

   localparam int                CNT_W     = $clog2(MMIO_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MMIO_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   state_t            state_q, state_d;
   logic              pending_q, pending_d;
   logic [2:0]        fnc_q, fnc_d;
   logic [1:0]        off_q, off_d;
   region_t           region_q, region_d;
   logic              mis_q, mis_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   region_t           ex_region;
   logic              ex_mis;
   logic              accept;
   logic              mmio_done;
   logic              mmio_expire;
   logic [31:0]       rdata_sel;
   logic [31:0]       aligned;

   // Decode the EX instruction; acceptance is also held off during reset so
   // no enable or request escapes while rst_n is low.
   always_comb begin
      ex_region = decode_region(ex_addr[31:28]);
`ifdef LOAD_CONTROL_MISALIGN_EN
      ex_mis    = is_misaligned(ex_fnc, ex_addr[1:0]);
`else
      ex_mis    = 1'b0;
`endif
      accept    = rst_n && ex_valid && (ex_opcode == OPC_LOAD) && (state_q == ST_IDLE);
   end

   // FSM next-state, access bookkeeping and handshake outputs.
   always_comb begin
      state_d     = state_q;
      pending_d   = 1'b0;
      fnc_d       = fnc_q;
      off_d       = off_q;
      region_d    = region_q;
      mis_d       = mis_q;
      cnt_d       = cnt_q;
      dmem_en     = 1'b0;
      bios_en     = 1'b0;
      mmio_req    = 1'b0;
      stall       = 1'b0;
      mmio_done   = 1'b0;
      mmio_expire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               fnc_d    = ex_fnc;
               off_d    = ex_addr[1:0];
               region_d = ex_region;
               mis_d    = ex_mis;
               dmem_en  = (ex_region == REGION_DMEM);
               bios_en  = (ex_region == REGION_BIOS);
               // A misaligned MMIO load is never sent out; it completes
               // next cycle like a fixed-latency access.
               if ((ex_region == REGION_MMIO) && !ex_mis) begin
                  mmio_req = 1'b1;
                  cnt_d    = '0;
                  state_d  = ST_WAIT_MMIO;
               end else begin
                  pending_d = 1'b1;
               end
            end
         end
         ST_WAIT_MMIO: begin
            // Data arriving on the timeout cycle still wins over the timeout.
            if (mmio_rvalid) begin
               mmio_done = 1'b1;
               state_d   = ST_IDLE;
            end else if (cnt_q == CNT_LIMIT) begin
               mmio_expire = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and access registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pending_q <= 1'b0;
         fnc_q     <= 3'b000;
         off_q     <= 2'b00;
         region_q  <= REGION_NONE;
         mis_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         fnc_q     <= fnc_d;
         off_q     <= off_d;
         region_q  <= region_d;
         mis_q     <= mis_d;
         cnt_q     <= cnt_d;
      end
   end

   // Select the returned word for the access being completed this cycle.
   // A timeout or an unmapped region returns zero.
   always_comb begin
      rdata_sel = '0;
      if (state_q == ST_WAIT_MMIO) begin
         if (mmio_done) begin
            rdata_sel = mmio_rdata;
         end
      end else begin
         case (region_q)
            REGION_DMEM: rdata_sel = dmem_rdata;
            REGION_BIOS: rdata_sel = bios_rdata;
            default:     rdata_sel = '0;
         endcase
      end
   end

   load_align u_align (
      .rdata   (rdata_sel),
      .fnc     (fnc_q),
      .offset  (off_q),
      .wb_data (aligned)
   );

   // Writeback outputs; wb_data is held at zero whenever nothing completes.
   always_comb begin
      wb_valid     = pending_q || mmio_done || mmio_expire;
      wb_data      = (wb_valid && !mis_q) ? aligned : '0;
      mmio_timeout = mmio_expire;
`ifdef LOAD_CONTROL_MISALIGN_EN
      misalign     = pending_q && mis_q;
`endif
   end

endmodule

// File: tb/tb_load_control.sv
// Self-checking bench for load_control. Loads are issued from tasks; each
// accepted load pushes its expected writeback into exp_q, and a negedge
// monitor pops and compares whenever wb_valid is high.
// Honours LOAD_CONTROL_MISALIGN_EN when compiled with it.
module tb_load_control;

   localparam int         TO      = 16;
   localparam logic [6:0] LOAD_OP = 7'b0000011;
   localparam logic [6:0] STORE_OP = 7'b0100011;
   localparam int K_IDLE = 0, K_DMEM = 1, K_BIOS = 2, K_NREG = 3, K_MMIO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_fnc;
   logic [31:0] ex_addr;
   logic        dmem_en, bios_en, mmio_req;
   logic [31:0] dmem_rdata, bios_rdata, mmio_rdata;
   logic        mmio_rvalid;
   logic        stall, wb_valid, mmio_timeout;
   logic [31:0] wb_data;
`ifdef LOAD_CONTROL_MISALIGN_EN
   logic        misalign;
`endif

   int total = 0;
   int bad   = 0;
   logic [32:0] exp_q[$];   // {expected misalign, expected wb_data}
   int          prev_kind = K_IDLE;
   logic [31:0] prev_rd   = '0;

   load_control #(.MMIO_TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_opcode    (ex_opcode),
      .ex_fnc       (ex_fnc),
      .ex_addr      (ex_addr),
      .dmem_en      (dmem_en),
      .bios_en      (bios_en),
      .mmio_req     (mmio_req),
      .dmem_rdata   (dmem_rdata),
      .bios_rdata   (bios_rdata),
      .mmio_rdata   (mmio_rdata),
      .mmio_rvalid  (mmio_rvalid),
      .stall        (stall),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .mmio_timeout (mmio_timeout)
`ifdef LOAD_CONTROL_MISALIGN_EN
      ,
      .misalign     (misalign)
`endif
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int kind_of(input logic [31:0] addr);
      int n;
      n = int'(addr[31:28]);
      if (n == 1 || n == 3) return K_DMEM;
      if (n == 4) return K_BIOS;
      if (n == 8) return K_MMIO;
      return K_NREG;
   endfunction

   function automatic logic exp_mis(input logic [2:0] fnc, input logic [1:0] off);
`ifdef LOAD_CONTROL_MISALIGN_EN
      if ((fnc == 3'd1 || fnc == 3'd5) && off[0]) return 1'b1;
      if (fnc == 3'd2 && off != 2'd0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Little-endian byte view: byte lanes past the top of the word read as 0.
   function automatic logic [31:0] ref_load(input int kind, input logic [2:0] fnc,
                                            input logic [1:0] off, input logic [31:0] rd);
      int unsigned by [5];
      int unsigned o, h;
      for (int i = 0; i < 4; i++) by[i] = (rd >> (8 * i)) & 32'hFF;
      by[4] = 0;
      o = off;
      h = by[o] + 256 * by[o + 1];
      if (kind == K_NREG) return '0;
      if (exp_mis(fnc, off)) return '0;
      case (fnc)
         3'd0:    return (by[o] >= 128) ? by[o] - 256 : by[o];
         3'd4:    return by[o];
         3'd1:    return (h >= 32768) ? h - 65536 : h;
         3'd5:    return h;
         3'd2:    return rd;
         default: return '0;
      endcase
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n && wb_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected: got wb_valid=1 data=%h required wb_valid=0 (t=%0t)",
                     wb_data, $time);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("wb_data", wb_data, e[31:0]);
`ifdef LOAD_CONTROL_MISALIGN_EN
            check("misalign", 32'(misalign), 32'(e[32]));
`endif
         end
      end
   end

   // ---------------- drivers ----------------
   // Present the read data owed to the previous cycle's DMEM/BIOS load and
   // put unrelated values on the other memory.
   task automatic apply_prev();
      dmem_rdata = $urandom;
      bios_rdata = $urandom;
      if (prev_kind == K_DMEM) dmem_rdata = prev_rd;
      if (prev_kind == K_BIOS) bios_rdata = prev_rd;
      prev_kind = K_IDLE;
   endtask

   // One EX cycle while the block is idle.
   task automatic step(input bit v, input logic [6:0] opc, input logic [2:0] fnc,
                       input logic [31:0] addr, input logic [31:0] rd);
      int  k;
      bit  ld;
      @(posedge clk);
      #1;
      apply_prev();
      mmio_rvalid = 1'($urandom_range(0, 1));
      mmio_rdata  = $urandom;
      ex_valid    = v;
      ex_opcode   = opc;
      ex_fnc      = fnc;
      ex_addr     = addr;
      ld = v && (opc == LOAD_OP);
      k  = kind_of(addr);
      if (ld) begin
         prev_kind = k;
         prev_rd   = rd;
         exp_q.push_back({exp_mis(fnc, addr[1:0]), ref_load(k, fnc, addr[1:0], rd)});
      end
      @(negedge clk);
      check("dmem_en", 32'(dmem_en), 32'(ld && k == K_DMEM));
      check("bios_en", 32'(bios_en), 32'(ld && k == K_BIOS));
      check("mmio_req_idle", 32'(mmio_req), 32'(0));
      check("stall_idle", 32'(stall), 32'(0));
   endtask

   // MMIO load; lat = cycles of stall before mmio_rvalid when respond=1.
   task automatic mmio_load(input logic [2:0] fnc, input logic [1:0] off, input int lat,
                            input bit respond, input logic [31:0] data);
      int stall_cnt, to_cnt, req_cnt, exp_lat;
      bit done;
      @(posedge clk);
      #1;
      apply_prev();
      mmio_rvalid = 1'($urandom_range(0, 1));
      mmio_rdata  = $urandom;
      ex_valid    = 1'b1;
      ex_opcode   = LOAD_OP;
      ex_fnc      = fnc;
      ex_addr     = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC) | 32'(off);
      exp_lat     = respond ? lat : TO;
      exp_q.push_back({1'b0, respond ? ref_load(K_MMIO, fnc, off, data) : 32'h0});
      @(negedge clk);
      check("mmio_req_issue", 32'(mmio_req), 32'(1));
      check("stall_issue", 32'(stall), 32'(0));
      done = 0; stall_cnt = 0; to_cnt = 0; req_cnt = 0;
      for (int k = 1; k <= 40 && !done; k++) begin
         @(posedge clk);
         #1;
         mmio_rvalid = respond && (k == lat + 1);
         mmio_rdata  = mmio_rvalid ? data : $urandom;
         dmem_rdata  = $urandom;
         bios_rdata  = $urandom;
         // Other loads on EX must be ignored while the MMIO read is open.
         ex_valid    = 1'b1;
         ex_opcode   = LOAD_OP;
         ex_fnc      = 3'($urandom_range(0, 7));
         ex_addr     = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
         @(negedge clk);
         if (stall) stall_cnt++;
         if (mmio_timeout) to_cnt++;
         if (mmio_req) req_cnt++;
         if (wb_valid) done = 1;
      end
      check("mmio_complete", 32'(done), 32'(1));
      check("mmio_stall_cycles", 32'(stall_cnt), 32'(exp_lat));
      check("mmio_timeout_pulses", 32'(to_cnt), respond ? 32'(0) : 32'(1));
      check("mmio_req_extra", 32'(req_cnt), 32'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wb_valid"}, 32'(wb_valid), 32'(0));
      check({tag, "_wb_data"}, wb_data, 32'(0));
      check({tag, "_stall"}, 32'(stall), 32'(0));
      check({tag, "_mmio_req"}, 32'(mmio_req), 32'(0));
      check({tag, "_mmio_timeout"}, 32'(mmio_timeout), 32'(0));
`ifdef LOAD_CONTROL_MISALIGN_EN
      check({tag, "_misalign"}, 32'(misalign), 32'(0));
`endif
   endtask

   // Reset while an MMIO read is outstanding; a late response must be dropped.
   task automatic reset_mid_wait();
      @(posedge clk);
      #1;
      apply_prev();
      mmio_rvalid = 1'b0;
      ex_valid    = 1'b1;
      ex_opcode   = LOAD_OP;
      ex_fnc      = 3'd2;
      ex_addr     = 32'h8000_0040;
      repeat (3) begin
         @(posedge clk);
         #1;
         mmio_rvalid = 1'b0;
      end
      @(negedge clk);
      check("rst_pre_stall", 32'(stall), 32'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      ex_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         mmio_rvalid = 1'b1;
         mmio_rdata  = $urandom;
         @(negedge clk);
         check("late_rvalid_wb", 32'(wb_valid), 32'(0));
         check("late_rvalid_stall", 32'(stall), 32'(0));
      end
      mmio_rvalid = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr(input int kind);
      logic [3:0] n;
      case (kind)
         K_DMEM:  n = $urandom_range(0, 1) ? 4'h1 : 4'h3;
         K_BIOS:  n = 4'h4;
         default: begin
            do n = 4'($urandom_range(0, 15));
            while (n == 4'h1 || n == 4'h3 || n == 4'h4 || n == 4'h8);
         end
      endcase
      return {n, 28'($urandom)};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rst_n       = 1'b0;
      ex_valid    = 1'b0;
      ex_opcode   = '0;
      ex_fnc      = '0;
      ex_addr     = '0;
      dmem_rdata  = '0;
      bios_rdata  = '0;
      mmio_rdata  = '0;
      mmio_rvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      check("reset_dmem_en", 32'(dmem_en), 32'(0));
      check("reset_bios_en", 32'(bios_en), 32'(0));
      #2;
      rst_n = 1'b1;

      // Directed: byte/halfword alignment and extension
      step(1, LOAD_OP, 3'd0, 32'h1000_0003, 32'h80FF_0000);   // LB  -> FFFFFF80
      step(1, LOAD_OP, 3'd4, 32'h1000_0003, 32'h80FF_0000);   // LBU -> 00000080
      step(1, LOAD_OP, 3'd5, 32'h4000_0002, 32'hBEEF_1234);   // LHU -> 0000BEEF
      step(1, LOAD_OP, 3'd1, 32'h4000_0000, 32'h0000_8001);   // LH  -> FFFF8001
      step(1, LOAD_OP, 3'd1, 32'h3000_0007, 32'h8012_3456);   // LH off 3 -> 00000080
      step(1, LOAD_OP, 3'd2, 32'h1000_0010, 32'hCAFE_0001);   // back-to-back LW
      step(1, LOAD_OP, 3'd2, 32'h3000_0020, 32'hCAFE_0002);
      step(1, LOAD_OP, 3'd2, 32'h1000_0002, 32'hAABB_CCDD);   // misaligned LW
      step(1, LOAD_OP, 3'd3, 32'h1000_0000, 32'h1234_5678);   // reserved
      step(1, LOAD_OP, 3'd6, 32'h4000_0000, 32'h1234_5678);   // reserved
      step(1, LOAD_OP, 3'd7, 32'h1000_0000, 32'hFFFF_FFFF);   // reserved
      step(1, LOAD_OP, 3'd2, 32'h2000_0000, 32'h1111_1111);   // unmapped region
      step(1, STORE_OP, 3'd2, 32'h1000_0000, 32'h0);          // not a load
      step(0, LOAD_OP, 3'd2, 32'h1000_0000, 32'h0);           // invalid EX
      step(0, 7'd0, 3'd0, 32'h0, 32'h0);

      // Directed MMIO: response after 3, timeout, response on the timeout cycle, immediate
      mmio_load(3'd2, 2'd0, 3, 1, 32'h1234_5678);
      mmio_load(3'd2, 2'd0, 0, 0, 32'h0);
      mmio_load(3'd2, 2'd0, TO, 1, 32'h5A5A_A5A5);
      mmio_load(3'd0, 2'd1, 0, 1, 32'h0000_F000);
`ifdef LOAD_CONTROL_MISALIGN_EN
      step(1, LOAD_OP, 3'd2, 32'h8000_0001, 32'h0);           // misaligned MMIO: no request
      step(1, LOAD_OP, 3'd1, 32'h4000_0003, 32'hFFFF_FFFF);
`endif
      step(0, 7'd0, 3'd0, 32'h0, 32'h0);

      reset_mid_wait();

      // Random traffic
      repeat (250) begin
         int r;
         logic [2:0] f;
         r = $urandom_range(0, 99);
         f = 3'($urandom_range(0, 7));
         if (r < 40) begin
            step(1, LOAD_OP, f, rand_addr(K_DMEM), $urandom);
         end else if (r < 60) begin
            step(1, LOAD_OP, f, rand_addr(K_BIOS), $urandom);
         end else if (r < 68) begin
            step(1, LOAD_OP, f, rand_addr(K_NREG), $urandom);
         end else if (r < 80) begin
            if ($urandom_range(0, 1) != 0)
               step(0, LOAD_OP, f, rand_addr(K_DMEM), $urandom);
            else
               step(1, 7'($urandom_range(0, 127)) | 7'b0010000, f, rand_addr(K_DMEM), $urandom);
         end else begin
            logic [1:0] o;
            if (f == 3'd2) o = 2'd0;
            else if (f == 3'd1 || f == 3'd5) o = 2'($urandom_range(0, 1) * 2);
            else o = 2'($urandom_range(0, 3));
            mmio_load(f, o, $urandom_range(0, TO), $urandom_range(0, 4) != 0, $urandom);
         end
      end

      step(0, 7'd0, 3'd0, 32'h0, 32'h0);
      step(0, 7'd0, 3'd0, 32'h0, 32'h0);
      check("exp_q_drained", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_control.md
# load_control

Load-side counterpart to the store write-enable/formatting logic in the RISC-V core. It decodes a load in EX, issues read enables to data memory, BIOS memory or MMIO, and tracks the access into the next cycle. It then aligns and sign- or zero-extends the returned word into a writeback value. It also stalls the pipeline while a variable-latency MMIO read completes.

## Interface
- MMIO_TIMEOUT, 16: max cycles waiting for `mmio_rvalid` before forcing completion.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  instruction in EX is valid.
- ex_opcode  in  7  EX opcode; only `OPC_LOAD` acts.
- ex_fnc  in  3  funct3 (LB/LH/LW/LBU/LHU).
- ex_addr  in  32  effective byte address.
- dmem_en  out  1  data-memory read enable; combinational, EX cycle.
- bios_en  out  1  BIOS-memory read enable; combinational, EX cycle.
- mmio_req  out  1  one-cycle MMIO read request pulse.
- dmem_rdata  in  32  dmem word, valid cycle after `dmem_en`.
- bios_rdata  in  32  BIOS word, valid cycle after `bios_en`.
- mmio_rdata  in  32  MMIO word, valid with `mmio_rvalid`.
- mmio_rvalid  in  1  MMIO data-valid strobe.
- stall  out  1  freeze IF/ID/EX.
- wb_valid  out  1  `wb_data` holds a completed load.
- wb_data  out  32  aligned, extended load result.
- mmio_timeout  out  1  one-cycle pulse; MMIO read abandoned.
- misalign  out  1  load address misaligned; present only with macro.

## Operation
- Region decode on `ex_addr[31:28]`:
  - 4'b00x1 → DMEM.
  - 4'b0100 → BIOS.
  - 4'b1000 → MMIO.
  - Anything else → NONE, which returns 0.
- Load accepted when `ex_valid & ex_opcode==OPC_LOAD & state==IDLE`.
- On accept, register: `fnc`, `addr[1:0]`, region, and a pending bit.
- FSM states:
  - IDLE: DMEM/BIOS/NONE loads set pending; MMIO loads pulse `mmio_req` and go to WAIT_MMIO.
  - WAIT_MMIO: `stall=1`. On `mmio_rvalid`, complete and return to IDLE. When the cycle counter reaches MMIO_TIMEOUT, complete with data 0, pulse `mmio_timeout`, and return to IDLE.
- Counter width is $clog2(MMIO_TIMEOUT+1). It clears on entry to WAIT_MMIO.
- Alignment: raw = `rdata >> (8*addr[1:0])`.
  - LB: sext raw[7:0]. LBU: zext raw[7:0].
  - LH: sext raw[15:0]. LHU: zext raw[15:0].
  - LW: raw unshifted (`rdata`).
  - Bytes shifted in from above bit 31 are 0.
- Reserved funct3 (3'b011, 3'b110, 3'b111): complete with `wb_data=0`.
- Non-load or invalid EX: no enables, no pending, `wb_valid=0` next cycle.

## Timing
- Reset values: `wb_valid=0`, `wb_data=0`, `stall=0`, `mmio_req=0`, `mmio_timeout=0`, `misalign=0`. State is IDLE, pending and counter are cleared.
- DMEM/BIOS/NONE loads:
  - Accept in cycle N.
  - `wb_valid=1` in N+1, with `wb_data` combinational from that cycle's rdata.
  - Back-to-back loads every cycle: zero bubbles.
- MMIO loads:
  - Accept in N, `mmio_req=1` in N only.
  - `stall=1` from N+1 until the completion cycle.
  - Completion cycle C (`mmio_rvalid` high): `wb_valid=1`, `wb_data` from `mmio_rdata`, `stall=0`.
  - A new load may be accepted in C+1.
- `mmio_rvalid` is ignored outside WAIT_MMIO.
- `mmio_rvalid` arriving in the same cycle the counter hits MMIO_TIMEOUT: treated as valid data, no timeout pulse.
- While `stall=1`, EX inputs are ignored.
- Reset asserted mid-WAIT_MMIO: return to IDLE asynchronously, outputs go to reset values. A late `mmio_rvalid` is then dropped.

## Configuration
- `LOAD_CONTROL_MISALIGN_EN` defined:
  - `misalign` port exists.
  - Misaligned cases: LH/LHU with `addr[0]=1`, LW with `addr[1:0]!=0`.
  - Misaligned loads still complete but force `wb_data=0`, and `misalign=1` in the `wb_valid` cycle.
  - MMIO misaligned loads issue no `mmio_req` and complete in N+1 without stall.
- Undefined: no `misalign` port; misaligned loads use the shift rule above unchanged.

## Structure
- Region encodings and address nibble constants go in a shared `MemMap.vh`, also used by store control. Opcode/funct3 come from `Opcode.vh`.
- One combinational sub-module `load_align` (rdata, fnc, offset → wb_data) holds the extract/extend logic.

## Test plan
- DMEM LB at 0x1000_0003 with dmem_rdata=0x80FF_0000 → next cycle `wb_valid=1`, `wb_data=0xFFFF_FF80`. The same access as LBU → `0x0000_0080`.
- BIOS LHU at 0x4000_0002 with bios_rdata=0xBEEF_1234 → `wb_data=0x0000_BEEF`. LH at 0x4000_0000 with 0x0000_8001 → `0xFFFF_8001`.
- MMIO LW at 0x8000_0010, `mmio_rvalid` after 3 cycles with 0x1234_5678 → `mmio_req` one pulse; `stall` high for exactly 3 cycles; then `wb_valid=1`, `wb_data=0x1234_5678`, `stall=0`.
- MMIO read with no response, MMIO_TIMEOUT=16 → `stall` ends at count 16, with `mmio_timeout=1`, `wb_valid=1`, `wb_data=0`.
- Two DMEM LWs in consecutive cycles → `wb_valid` high two consecutive cycles with matching data. Then reset mid-WAIT_MMIO → all outputs 0 and no `wb_valid` afterward.
- With `LOAD_CONTROL_MISALIGN_EN`: LW at 0x1000_0002 → `misalign=1`, `wb_data=0`. Without the macro → shifted data returned, no flag.
